aes_key_schedule: RTL
=====================

// Module: aes_key_schedule
// PURPOSE
//   Multi-mode AES key expansion (FIPS-197) for AES-128/192/256, one 32-bit word per clock.
//   Stores the expanded schedule internally; the cipher datapath fetches 128-bit round keys
//   through a registered read port instead of a flat array output.
//   Sits between the key register file and the AES round engine; start/busy/ready handshake.
// PARAMETERS
//   MAX_KEY_BITS  256  largest supported key (128|192|256); sizes key port and word store (4*(MAX_NR+1) words)
// PORTS
//   ACLK       in   1             clock
//   ARSTn      in   1             reset, synchronous, active-low
//   start      in   1             request expansion; sampled when state is IDLE or READY
//   key_len    in   2             0=128, 1=192, 2=256, 3=illegal; captured with start
//   key        in   MAX_KEY_BITS  cipher key, MSB-aligned (AES-128 uses key[MAX-1 -: 128])
//   busy       out  1             high in LOAD/EXPAND
//   ready      out  1             schedule complete and valid (state READY)
//   done       out  1             one-cycle pulse on the edge entering READY
//   cfg_err    out  1             one-cycle pulse: start with key_len illegal or > MAX_KEY_BITS
//   rk_rd      in   1             round-key read request
//   rk_idx     in   4             round number 0..Nr
//   rk_vld     out  1             rk_out valid (1 cycle after rk_rd)
//   rk_err     out  1             with rk_vld: read rejected (not ready or rk_idx > Nr)
//   rk_out     out  128           {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
// BEHAVIOUR
//   Reset: state IDLE; busy/ready/done/cfg_err/rk_vld/rk_err=0; rk_out=0; word store not cleared.
//   Derived: Nk=4/6/8, Nr=10/12/14, Nw=4*(Nr+1)=44/52/60 per captured key_len.
//   FSM: IDLE -start(legal)-> LOAD -> EXPAND -(i==Nw-1 written)-> READY -start(legal)-> LOAD.
//   - start with illegal key_len: ignored, state unchanged, cfg_err pulses.
//   - start while busy: ignored (no error). key/key_len changes after capture: no effect.
//   Timing (E0 = edge sampling legal start): E0 captures key/key_len, enters LOAD, ready->0.
//   E1 writes w[0..Nk-1] from key, i<=Nk, enters EXPAND. Each EXPAND edge writes w[i], i++.
//   ready=1,done=1 after edge E(1+Nw-Nk): E41 (128), E47 (192), E53 (256).
//   Word rule: t=w[i-1]; if i%Nk==0: t=SubWord(RotWord(t))^{Rcon[i/Nk],24'h0};
//     else if Nk==8 && i%8==4: t=SubWord(t); w[i]=w[i-Nk]^t.
//   Rcon = 01,02,04,08,10,20,40,80,1b,36 (index 1..10); i%Nk via counter, no divider.
//   Read: rk_rd sampled at edge; next cycle rk_vld=1 with rk_out, or rk_err=1 and rk_out=0 if
//     ready==0 at sampling edge or rk_idx>Nr. rk_vld/rk_err are single-cycle per request.
//   Simultaneous rk_rd and restart at E0: read uses ready=1 and returns the old schedule
//     (store not overwritten until E1). Reads during LOAD/EXPAND -> rk_err.
//   Reset mid-expansion: return to IDLE next edge; partial schedule discarded (ready=0).
// TESTING
//   AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start -> ready/done after E41;
//     rk_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rk_idx=0 -> the key itself.
//   AES-192 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> ready after E47;
//     rk_idx=12 -> e98ba06f_448c773c_8ecc7204_01002202.
//   AES-256 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4
//     -> ready after E53; rk_idx=14 -> fe4890d1_e6188d0b_046df344_706c631e.
//   key_len=3 start -> cfg_err pulse, stays IDLE; AES-128 ready, rk_idx=11 -> rk_err, rk_out=0.
//   Restart in READY with rk_rd same edge -> old key's round returned; then new schedule correct.
//   ARSTn low at E20 of AES-256 run -> IDLE, ready=0; rk_rd -> rk_err; fresh start completes.

Source files
------------

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128/192/256 key expansion, one word per clock, with registered round-key read port.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    ACLK,
    input  logic                    ARSTn,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key,
    output logic                    busy,
    output logic                    ready,
    output logic                    done,
    output logic                    cfg_err,
    input  logic                    rk_rd,
    input  logic [3:0]              rk_idx,
    output logic                    rk_vld,
    output logic                    rk_err,
    output logic [127:0]            rk_out
);

    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int MAX_NR = MAX_NK + 6;
    localparam int WORDS  = 4 * (MAX_NR + 1);
    localparam int IW     = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        READY
    } state_t;

    state_t state_q, state_d;

    logic [31:0]             store [WORDS];
    logic [MAX_KEY_BITS-1:0] key_q;
    logic [3:0]              nk_q;
    logic [3:0]              nr_q;
    logic [IW-1:0]           last_q;
    logic [IW-1:0]           idx_q;
    logic [3:0]              mod_q;
    logic [7:0]              rcon_q;

    logic        len_ok;
    logic        accept;
    logic        start_ok;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] t_word;
    logic [31:0] w_new;
    logic [3:0]  rd_idx;
    logic [IW-1:0] rd_base;
    logic [127:0] rd_word;
    logic        done_q;
    logic        cfg_err_q;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        case (key_len)
            2'd0:    len_ok = 1'b1;
            2'd1:    len_ok = (MAX_KEY_BITS >= 192);
            2'd2:    len_ok = (MAX_KEY_BITS >= 256);
            default: len_ok = 1'b0;
        endcase
    end

    assign accept   = start && ((state_q == IDLE) || (state_q == READY));
    assign start_ok = accept && len_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (start_ok) state_d = LOAD;
            LOAD:        state_d = EXPAND;
            EXPAND:      if (idx_q == last_q) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_q == EXPAND) && (state_d == READY);
            cfg_err_q <= accept && !len_ok;
        end
    end

    assign busy    = (state_q == LOAD) || (state_q == EXPAND);
    assign ready   = (state_q == READY);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    // mod_q tracks i % Nk so the word rule needs no divider.
    always_comb begin
        w_prev = store[idx_q - IW'(1)];
        w_back = store[idx_q - IW'(nk_q)];
        t_word = w_prev;
        if (mod_q == 4'd0)
            t_word = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        else if ((nk_q == 4'd8) && (mod_q == 4'd4))
            t_word = sub_word(w_prev);
        w_new = w_back ^ t_word;
    end

    always_ff @(posedge ACLK) begin
        if (start_ok) begin
            key_q <= key;
            case (key_len)
                2'd0: begin
                    nk_q   <= 4'd4;
                    nr_q   <= 4'd10;
                    last_q <= IW'(43);
                end
                2'd1: begin
                    nk_q   <= 4'd6;
                    nr_q   <= 4'd12;
                    last_q <= IW'(51);
                end
                default: begin
                    nk_q   <= 4'd8;
                    nr_q   <= 4'd14;
                    last_q <= IW'(59);
                end
            endcase
        end
        if (ARSTn) begin
            if (state_q == LOAD) begin
                for (int j = 0; j < MAX_NK; j++) begin
                    if (4'(j) < nk_q) store[IW'(j)] <= key_q[MAX_KEY_BITS-1-32*j -: 32];
                end
                idx_q  <= IW'(nk_q);
                mod_q  <= 4'd0;
                rcon_q <= 8'h01;
            end else if (state_q == EXPAND) begin
                store[idx_q] <= w_new;
                idx_q        <= idx_q + IW'(1);
                mod_q        <= (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
                if (mod_q == 4'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end
    end

    // Clamp keeps the address inside the store; out-of-range requests are rejected anyway.
    assign rd_idx  = (rk_idx > 4'(MAX_NR)) ? 4'd0 : rk_idx;
    assign rd_base = IW'({rd_idx, 2'b00});
    assign rd_word = {store[rd_base], store[rd_base + IW'(1)],
                      store[rd_base + IW'(2)], store[rd_base + IW'(3)]};

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            rk_vld <= 1'b0;
            rk_err <= 1'b0;
            rk_out <= '0;
        end else begin
            rk_vld <= rk_rd;
            rk_err <= 1'b0;
            if (rk_rd) begin
                if ((state_q == READY) && (rk_idx <= nr_q)) begin
                    rk_out <= rd_word;
                end else begin
                    rk_err <= 1'b1;
                    rk_out <= '0;
                end
            end
        end
    end

endmodule
